lab2_1_checker: RTL and testbench

Receive-side checker for the 6-bit up/down counter sequence produced by the lab counter generator. It samples one 6-bit value per valid cycle and predicts the next value with the generator's recurrence. It flags every mismatch and resynchronises on its own. It sits downstream of the generator, or of any link carrying the sequence, and gives the board a lock indicator, an error pulse and a saturating error count.

---
 rtl/lab2_1_checker_if.sv | 23 ++
 rtl/lab2_1_checker.sv | 123 ++++++++++++
 tb/tb_lab2_1_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lab2_1_checker_if.sv
// Link between the counter-sequence source and the checker: sample stream in,
// lock/phase/error status back out.
interface lab2_1_checker_if #(
  parameter int ERR_W = 8
) ();
  logic             in_valid;
  logic [5:0]       cnt_in;
  logic             locked;
  logic             phase;
  logic             err;
  logic             done;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output in_valid, cnt_in,
    input  locked, phase, err, done, err_cnt
  );

  modport slave (
    input  in_valid, cnt_in,
    output locked, phase, err, done, err_cnt
  );
endinterface

// File: rtl/lab2_1_checker.sv
// Receive-side checker for the 6-bit up/down counter sequence: predicts each
// sample from the generator recurrence, flags mismatches and relocks by itself.
module lab2_1_checker #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  lab2_1_checker_if.slave  bus
);

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  state_t           state_p0, state_p1;
  logic [5:0]       prev_p0, prev_p1;
  logic [7:0]       n_p0, n_p1;
  logic             down_p0, down_p1;
  logic             err_p0, err_p1;
  logic             done_p0, done_p1;
  logic [ERR_W-1:0] err_cnt_p0, err_cnt_p1;

  logic             vld_p0;
  logic [5:0]       smp_p0;
  logic [5:0]       pred_p0;
  logic             match_p0;
  logic             seg_end_p0;

  // Upward compares zero-extended prev against n; downward subtracts 2^(n-1),
  // which vanishes once the shift would leave the 6-bit range.
  function automatic logic [5:0] predict(input logic [5:0] prev,
                                         input logic [7:0] n,
                                         input logic       down);
    logic [7:0] prev_x;
    logic [7:0] sum;
    logic [7:0] sh;
    logic [5:0] sub;
    prev_x = {2'b00, prev};
    sum    = (prev_x > n) ? (prev_x - n) : (prev_x + n);
    sh     = n - 8'd1;
    sub    = (sh < 8'd6) ? (6'd1 << sh[2:0]) : 6'd0;
    return down ? (prev - sub) : sum[5:0];
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : (x + {{(ERR_W-1){1'b0}}, 1'b1});
  endfunction

  // Stage 0: incoming sample against the prediction from registered state
  assign vld_p0     = bus.in_valid;
  assign smp_p0     = bus.cnt_in;
  assign pred_p0    = predict(prev_p1, n_p1, down_p1);
  assign match_p0   = (smp_p0 == pred_p0);
  assign seg_end_p0 = down_p1 ? (smp_p0 == 6'd0) : (smp_p0 == 6'd63);

  always_comb begin
    state_p0   = state_p1;
    prev_p0    = prev_p1;
    n_p0       = n_p1;
    down_p0    = down_p1;
    err_p0     = 1'b0;
    done_p0    = 1'b0;
    err_cnt_p0 = err_cnt_p1;
    if (vld_p0) begin
      if (state_p1 == HUNT) begin
        if (smp_p0 == 6'd0) begin
          state_p0 = TRACK;
          prev_p0  = 6'd0;
          n_p0     = 8'd1;
          down_p0  = 1'b0;
        end
      end else if (match_p0) begin
        prev_p0 = smp_p0;
        if (seg_end_p0) begin
          n_p0    = 8'd1;
          down_p0 = ~down_p1;
          done_p0 = down_p1;
        end else begin
          n_p0 = n_p1 + 8'd1;
        end
      end else begin
        err_p0     = 1'b1;
        err_cnt_p0 = sat_inc(err_cnt_p1);
        // A received 0 is always a valid period start, so relock on it directly
        if (smp_p0 == 6'd0) begin
          prev_p0 = 6'd0;
          n_p0    = 8'd1;
          down_p0 = 1'b0;
        end else begin
          state_p0 = HUNT;
        end
      end
    end
  end

  // Stage 1: registered tracker state and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1   <= HUNT;
      prev_p1    <= 6'd0;
      n_p1       <= 8'd1;
      down_p1    <= 1'b0;
      err_p1     <= 1'b0;
      done_p1    <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      state_p1   <= state_p0;
      prev_p1    <= prev_p0;
      n_p1       <= n_p0;
      down_p1    <= down_p0;
      err_p1     <= err_p0;
      done_p1    <= done_p0;
      err_cnt_p1 <= err_cnt_p0;
    end
  end

  always_comb begin
    bus.locked  = (state_p1 == TRACK);
    bus.phase   = down_p1;
    bus.err     = err_p1;
    bus.done    = done_p1;
    bus.err_cnt = err_cnt_p1;
  end

endmodule

// File: tb/tb_lab2_1_checker.sv
// Bench for lab2_1_checker: randomized streams compared against a model that
// tracks the position inside one golden period of the sequence.
module tb_lab2_1_checker;
  localparam int ERR_W = 8;
  localparam int PER   = 63;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lab2_1_checker_if #(.ERR_W(ERR_W)) bus ();
  lab2_1_checker #(.ERR_W(ERR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int gen[64];

  bit m_locked;
  int m_pos;
  int m_cnt;
  bit m_err;
  bit m_done;
  int n_err_seen;
  int n_done_seen;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic build_golden();
    int p, n, e;
    bit dn;
    p = 0; n = 1; dn = 0;
    gen[0] = 0;
    for (int k = 1; k < 64; k++) begin
      if (!dn) e = (p > n) ? p - n : p + n;
      else     e = p - (((n - 1) < 6) ? (1 << (n - 1)) : 0);
      e = e & 63;
      gen[k] = e;
      if ((!dn && e == 63) || (dn && e == 0)) begin
        n = 1; dn = ~dn;
      end else begin
        n++;
      end
      p = e;
    end
    if (gen[57] != 63 || gen[63] != 0) begin
      $display("FAIL golden_table got %0d/%0d exp 63/0", gen[57], gen[63]);
      $fatal(1);
    end
  endtask

  // Locked model state is just an index into the golden period.
  task automatic model_update(input bit r, input bit v, input int val);
    m_err  = 0;
    m_done = 0;
    if (r) begin
      m_locked = 0; m_pos = 0; m_cnt = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (val == 0) begin
          m_locked = 1; m_pos = 0;
        end
      end else if (val == gen[m_pos + 1]) begin
        m_pos++;
        if (m_pos == PER) begin
          m_pos = 0; m_done = 1;
        end
      end else begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        if (val == 0) m_pos = 0;
        else          m_locked = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int val);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.cnt_in   = val[5:0];
    @(posedge clk);
    #1;
    model_update(r, v, val);
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("err", int'(bus.err), int'(m_err));
    chk("done", int'(bus.done), int'(m_done));
    chk("err_cnt", int'(bus.err_cnt), m_cnt);
    if (r || m_locked)
      chk("phase", int'(bus.phase), (m_locked && m_pos >= 57) ? 1 : 0);
    if (bus.err)  n_err_seen++;
    if (bus.done) n_done_seen++;
  endtask

  task automatic clear_seen();
    n_err_seen  = 0;
    n_done_seen = 0;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'($urandom_range(1)), int'($urandom_range(63)));
    clear_seen();
  endtask

  // nper whole periods plus the closing 0; optional gaps and one corrupted index.
  task automatic send_periods(input int nper, input bit gaps, input int bad_idx);
    int val;
    for (int p = 0; p < nper; p++) begin
      for (int k = 0; k < PER; k++) begin
        val = (p == 0 && k == bad_idx) ? 5 : gen[k];
        while (gaps && $urandom_range(1) == 1) step(1'b0, 1'b0, int'($urandom_range(63)));
        step(1'b0, 1'b1, val);
      end
    end
    step(1'b0, 1'b1, 0);
  endtask

  initial begin
    int seq4[7] = '{0, 1, 3, 0, 1, 3, 6};
    int idx;
    int r;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.cnt_in   = '0;
    m_locked = 0; m_pos = 0; m_cnt = 0; m_err = 0; m_done = 0;
    build_golden();

    do_reset(2);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
    send_periods(3, 1'b0, -1);
    chk("clean_errs", n_err_seen, 0);
    chk("clean_dones", n_done_seen, 3);
    chk("clean_cnt", int'(bus.err_cnt), 0);

    do_reset(1);
    send_periods(2, 1'b0, 4);
    chk("corrupt_errs", n_err_seen, 1);
    chk("corrupt_cnt", int'(bus.err_cnt), 1);
    chk("corrupt_dones", n_done_seen, 1);

    do_reset(1);
    send_periods(2, 1'b1, -1);
    chk("gaps_errs", n_err_seen, 0);
    chk("gaps_dones", n_done_seen, 2);

    do_reset(1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, seq4[i]);
    chk("zero_relock_errs", n_err_seen, 1);
    chk("zero_relock_cnt", int'(bus.err_cnt), 1);
    chk("zero_relock_locked", int'(bus.locked), 1);

    do_reset(1);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b1, 5);
    end
    chk("sat_errs", n_err_seen, 300);
    chk("sat_cnt", int'(bus.err_cnt), 255);

    // Reset lands mid-downward while err_cnt still holds its saturated value
    clear_seen();
    for (int k = 0; k < 59; k++) step(1'b0, 1'b1, gen[k]);
    chk("midrun_phase_before", int'(bus.phase), 1);
    step(1'b1, 1'b1, gen[59]);
    chk("midrun_rst_locked", int'(bus.locked), 0);
    chk("midrun_rst_phase", int'(bus.phase), 0);
    chk("midrun_rst_cnt", int'(bus.err_cnt), 0);
    clear_seen();
    send_periods(1, 1'b0, -1);
    chk("midrun_errs", n_err_seen, 0);
    chk("midrun_dones", n_done_seen, 1);

    // Mixed stream: golden fragments, gaps and random noise
    do_reset(1);
    idx = 0;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(9));
      if (r < 7) begin
        step(1'b0, 1'b1, gen[idx]);
        idx = (idx + 1) % PER;
      end else if (r < 8) begin
        step(1'b0, 1'b0, int'($urandom_range(63)));
      end else begin
        step(1'b0, 1'b1, int'($urandom_range(63)));
      end
    end
    chk("mixed_cnt_final", int'(bus.err_cnt), m_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
